// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared defines for the memory controller.
// Holds the FSM state encoding, the LSB size codes, the IO address-range
// tag and small helpers used to decode sizes, IO addresses and byte lanes.
package mem_ctrl_pkg;

  // Controller states: idle, instruction fetch read, load read, store write.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_LS_RD = 2'd2,
    ST_LS_WR = 2'd3
  } state_t;

  // LSB_size codes (byte counts).
  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  // Instruction fetches are always one full word.
  localparam logic [2:0] IF_BYTES = 3'd4;

  // Address bits [17:16] equal to this value select the UART/IO range.
  localparam logic [1:0] IO_RANGE = 2'b11;

  // Byte count of a transfer; an unknown code degrades to a single byte.
  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // True when the upper tag bits of an address fall in the IO range.
  function automatic logic is_io(input logic [1:0] a_hi);
    return (a_hi == IO_RANGE);
  endfunction

  // Byte lane idx of a little-endian word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial RAM controller arbitrating instruction fetch (IF)
// and load/store (LSB) requests onto an 8-bit RAM port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes all state and outputs
//   clr               rollback flush (aborts reads, stores complete)
//   IF_req/IF_addr    fetch request (always 4 bytes) -> IF_done/IF_data
//   LSB_req/LSB_wr/LSB_addr/LSB_size/LSB_wdata
//                     load/store request -> LSB_done/LSB_rdata
//   mem_din           RAM read byte, valid one cycle after its address
//   mem_dout/mem_a/mem_wr  RAM write byte, byte address, write strobe
//   io_buffer_full    UART buffer full; stalls stores to the IO range
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_done,
  output logic [31:0] IF_data,
  input  logic        LSB_req,
  input  logic        LSB_wr,
  input  logic [31:0] LSB_addr,
  input  logic [2:0]  LSB_size,
  input  logic [31:0] LSB_wdata,
  output logic        LSB_done,
  output logic [31:0] LSB_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_last_lsb;
  logic        r_if_done;
  logic        r_lsb_done;
  logic [31:0] r_if_data;
  logic [31:0] r_lsb_rdata;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;

  logic        w_if_pend;
  logic        w_lsb_pend;
  logic        w_grant_lsb;
  logic        w_grant_if;
  logic [2:0]  w_lsb_n;
  logic        w_grant_hold;
  logic [2:0]  w_wr_next;
  logic [31:0] w_wr_addr;
  logic        w_wr_hold;
  logic [31:0] w_rd_addr;
  logic        w_rd_more;
  logic [1:0]  w_rd_idx;
  logic [31:0] w_rd_merged;

  // A requester whose done pulse is showing is masked so it is not granted twice.
  assign w_if_pend   = IF_req & ~r_if_done;
  assign w_lsb_pend  = LSB_req & ~r_lsb_done;
  // Round-robin on a tie: LSB wins unless it was the last one granted.
  assign w_grant_lsb = w_lsb_pend & (~w_if_pend | ~r_last_lsb);
  assign w_grant_if  = w_if_pend & ~w_grant_lsb;
  assign w_lsb_n     = size_bytes(LSB_size);
  assign w_grant_hold = is_io(LSB_addr[17:16]) & io_buffer_full;

  // Store path: the counter advances only past a byte that was really written.
  assign w_wr_next = r_cnt + {2'd0, r_mem_wr};
  assign w_wr_addr = r_addr + {29'd0, w_wr_next};
  assign w_wr_hold = is_io(w_wr_addr[17:16]) & io_buffer_full;

  // Read path: r_cnt is the byte addressed in the current cycle; the byte
  // returning on mem_din now belongs to the previous address.
  assign w_rd_addr = r_addr + {29'd0, r_cnt} + 32'd1;
  assign w_rd_more = ((r_cnt + 3'd1) < r_n);
  assign w_rd_idx  = r_cnt[1:0] - 2'd1;

  // Merge the returning byte into its little-endian lane of the read buffer.
  always_comb begin
    w_rd_merged = r_buf;
    case (w_rd_idx)
      2'd0:    w_rd_merged[7:0]   = mem_din;
      2'd1:    w_rd_merged[15:8]  = mem_din;
      2'd2:    w_rd_merged[23:16] = mem_din;
      2'd3:    w_rd_merged[31:24] = mem_din;
      default: w_rd_merged = r_buf;
    endcase
  end

  // Main FSM: arbitration, byte sequencing, done pulses and registered RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_last_lsb  <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_lsb_rdata <= 32'd0;
      r_mem_a     <= 32'd0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mem_a    <= 32'd0;
          r_mem_dout <= 8'd0;
          r_mem_wr   <= 1'b0;
          r_cnt      <= 3'd0;
          if (!clr && w_grant_lsb) begin
            r_last_lsb <= 1'b1;
            r_addr     <= LSB_addr;
            r_wdata    <= LSB_wdata;
            r_n        <= w_lsb_n;
            r_buf      <= 32'd0;
            r_mem_a    <= LSB_addr;
            if (LSB_wr) begin
              r_state    <= ST_LS_WR;
              r_mem_dout <= LSB_wdata[7:0];
              r_mem_wr   <= ~w_grant_hold;
            end else begin
              r_state <= ST_LS_RD;
            end
          end else if (!clr && w_grant_if) begin
            r_last_lsb <= 1'b0;
            r_addr     <= IF_addr;
            r_n        <= IF_BYTES;
            r_buf      <= 32'd0;
            r_mem_a    <= IF_addr;
            r_state    <= ST_IF_RD;
          end
        end
        ST_IF_RD, ST_LS_RD: begin
          if (clr) begin
            // Abort silently; the partial buffer never reaches the outputs.
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_mem_a <= 32'd0;
          end else if (r_cnt == r_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_mem_a <= 32'd0;
            if (r_state == ST_IF_RD) begin
              r_if_done <= 1'b1;
              r_if_data <= w_rd_merged;
            end else begin
              r_lsb_done  <= 1'b1;
              r_lsb_rdata <= w_rd_merged;
            end
          end else begin
            if (r_cnt != 3'd0) begin
              r_buf <= w_rd_merged;
            end
            r_cnt   <= r_cnt + 3'd1;
            r_mem_a <= w_rd_more ? w_rd_addr : 32'd0;
          end
        end
        ST_LS_WR: begin
          // Stores ignore clr: the data is already committed.
          if (w_wr_next == r_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_lsb_done <= 1'b1;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
          end else begin
            r_cnt      <= w_wr_next;
            r_mem_a    <= w_wr_addr;
            r_mem_dout <= byte_sel(r_wdata, w_wr_next[1:0]);
            r_mem_wr   <= ~w_wr_hold;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign IF_done   = r_if_done;
  assign IF_data   = r_if_data;
  assign LSB_done  = r_lsb_done;
  assign LSB_rdata = r_lsb_rdata;
  assign mem_a     = r_mem_a;
  assign mem_dout  = r_mem_dout;
  assign mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- self-checking bench for mem_ctrl: a registered-read RAM,
// a transaction-level reference model compared every cycle, and directed
// vectors with hand-computed expectations.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_done;
  logic [31:0] IF_data;
  logic        LSB_req;
  logic        LSB_wr;
  logic [31:0] LSB_addr;
  logic [2:0]  LSB_size;
  logic [31:0] LSB_wdata;
  logic        LSB_done;
  logic [31:0] LSB_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_done(IF_done), .IF_data(IF_data),
    .LSB_req(LSB_req), .LSB_wr(LSB_wr), .LSB_addr(LSB_addr), .LSB_size(LSB_size),
    .LSB_wdata(LSB_wdata), .LSB_done(LSB_done), .LSB_rdata(LSB_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sparse RAM: fold the address bits the bench uses into a 1 KiB array.
  logic [7:0] ram [0:1023];
  function automatic int ridx(input logic [31:0] a);
    return int'({a[17:16], a[12], a[6:0]});
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w = w | ({24'd0, ram[ridx(a + 32'(i))]} << (8 * i));
    return w;
  endfunction

  // RAM: registered read (byte valid the cycle after its address), byte write.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[ridx(32'h1000)] = 8'h13;
    ram[ridx(32'h1001)] = 8'h05;
    mem_din = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_wr === 1'b1) ram[ridx(mem_a)] <= mem_dout;
      mem_din <= ram[ridx(mem_a)];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected outputs for the current cycle; stepped with the inputs that the
  // coming rising edge will sample.
  bit          m_valid = 1'b0;
  int          m_kind = 0;        // 0 idle, 1 fetch, 2 load, 3 store
  int          m_n, m_t, m_k;
  bit          m_last_lsb;
  logic [31:0] m_addr, m_wdata, m_word;
  logic        e_if_done, e_lsb_done, e_mem_wr, e_hold;
  logic [31:0] e_mem_a, e_if_data, e_lsb_rdata;
  logic [7:0]  e_mem_dout;

  function automatic int model_size(input logic [2:0] s);
    return (s == 3'd2) ? 2 : (s == 3'd4) ? 4 : 1;
  endfunction

  task automatic model_write_cycle();
    logic [31:0] a;
    a          = m_addr + 32'(m_k);
    e_mem_a    = a;
    e_hold     = (a[17:16] == 2'b11) && io_buffer_full;
    e_mem_wr   = !e_hold;
    e_mem_dout = 8'(m_wdata >> (8 * m_k));
  endtask

  task automatic model_idle_outputs();
    e_mem_a = 32'd0; e_mem_wr = 1'b0; e_mem_dout = 8'd0; e_hold = 1'b0;
  endtask

  task automatic model_step();
    bit pif, plsb, take_lsb;
    if (rst) begin
      m_valid = 1'b1; m_kind = 0; m_last_lsb = 1'b0;
      e_if_done = 1'b0; e_lsb_done = 1'b0; e_if_data = 32'd0; e_lsb_rdata = 32'd0;
      model_idle_outputs();
    end else if (rdy) begin
      pif  = IF_req && !e_if_done;
      plsb = LSB_req && !e_lsb_done;
      e_if_done = 1'b0;
      e_lsb_done = 1'b0;
      case (m_kind)
        0: begin
          model_idle_outputs();
          if (!clr && (pif || plsb)) begin
            take_lsb = plsb && (!pif || !m_last_lsb);
            m_t = 0; m_k = 0;
            if (take_lsb) begin
              m_last_lsb = 1'b1; m_addr = LSB_addr; m_wdata = LSB_wdata;
              m_n = model_size(LSB_size); m_kind = LSB_wr ? 3 : 2;
            end else begin
              m_last_lsb = 1'b0; m_addr = IF_addr; m_n = 4; m_kind = 1;
            end
            if (m_kind == 3) model_write_cycle();
            else begin
              m_word  = ram_word(m_addr, m_n);
              e_mem_a = m_addr;
            end
          end
        end
        1, 2: begin
          if (clr) begin
            m_kind = 0; model_idle_outputs();
          end else begin
            m_t++;
            e_mem_a = (m_t < m_n) ? m_addr + 32'(m_t) : 32'd0;
            if (m_t == m_n + 1) begin
              if (m_kind == 1) begin e_if_done = 1'b1; e_if_data = m_word; end
              else begin e_lsb_done = 1'b1; e_lsb_rdata = m_word; end
              m_kind = 0;
            end
          end
        end
        default: begin
          if (e_mem_wr) m_k++;
          if (m_k == m_n) begin
            e_lsb_done = 1'b1; m_kind = 0; model_idle_outputs();
          end else model_write_cycle();
        end
      endcase
    end
  endtask

  // Compare on the falling edge, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model.IF_done",   {31'd0, IF_done},  {31'd0, e_if_done});
        chk("model.LSB_done",  {31'd0, LSB_done}, {31'd0, e_lsb_done});
        chk("model.mem_wr",    {31'd0, mem_wr},   {31'd0, e_mem_wr});
        chk("model.IF_data",   IF_data,   e_if_data);
        chk("model.LSB_rdata", LSB_rdata, e_lsb_rdata);
        if (!e_hold) begin
          chk("model.mem_a",    mem_a, e_mem_a);
          chk("model.mem_dout", {24'd0, mem_dout}, {24'd0, e_mem_dout});
        end
      end
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit want_if, input int max_c);
    int c;
    c = 0;
    while (!(want_if ? IF_done : LSB_done) && c < max_c) begin
      tick();
      c++;
    end
    chk(want_if ? "wait.IF_done" : "wait.LSB_done",
        {31'd0, (want_if ? IF_done : LSB_done)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
    IF_req = 1'b0; IF_addr = 32'd0;
    LSB_req = 1'b0; LSB_wr = 1'b0; LSB_addr = 32'd0; LSB_size = 3'd1; LSB_wdata = 32'd0;
    repeat (3) tick();
    chk("rst.IF_done", {31'd0, IF_done}, 32'd0);
    chk("rst.LSB_done", {31'd0, LSB_done}, 32'd0);
    chk("rst.mem_a", mem_a, 32'd0);
    chk("rst.mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst.mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst.IF_data", IF_data, 32'd0);
    chk("rst.LSB_rdata", LSB_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Simultaneous requests after reset: LSB first, IF at the LSB_done edge.
    IF_req = 1'b1; IF_addr = 32'h1000;
    LSB_req = 1'b1; LSB_wr = 1'b0; LSB_addr = 32'h1000; LSB_size = 3'd4;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) chk("arb.c0.mem_a", mem_a, 32'h1000);
      if (c == 5) begin
        chk("arb.LSB_done", {31'd0, LSB_done}, 32'd1);
        chk("arb.IF_done_early", {31'd0, IF_done}, 32'd0);
        chk("arb.LSB_rdata", LSB_rdata, 32'h0000_0513);
      end
      if (c == 6) begin
        LSB_req = 1'b0;
        chk("arb.if_start.mem_a", mem_a, 32'h1000);
        chk("arb.no_second_lsb", {31'd0, LSB_done}, 32'd0);
      end
      if (c == 11) begin
        chk("arb.IF_done", {31'd0, IF_done}, 32'd1);
        chk("arb.IF_data", IF_data, 32'h0000_0513);
      end
    end
    tick(); IF_req = 1'b0;
    repeat (3) tick();

    // Fetch of 0x1000.
    IF_req = 1'b1; IF_addr = 32'h1000;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c < 4) chk("if.mem_a", mem_a, 32'h1000 + 32'(c));
      if (c == 4) chk("if.mem_a_idle", mem_a, 32'd0);
      chk("if.IF_done", {31'd0, IF_done}, (c == 5) ? 32'd1 : 32'd0);
    end
    chk("if.IF_data", IF_data, 32'h0000_0513);
    tick(); IF_req = 1'b0;
    repeat (2) tick();

    // Half-word store to 0x20.
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h20; LSB_size = 3'd2; LSB_wdata = 32'hAABB_CCDD;
    tick();
    chk("st.c0.mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("st.c0.mem_a", mem_a, 32'h20);
    chk("st.c0.mem_dout", {24'd0, mem_dout}, 32'hDD);
    tick();
    chk("st.c1.mem_a", mem_a, 32'h21);
    chk("st.c1.mem_dout", {24'd0, mem_dout}, 32'hCC);
    tick();
    chk("st.c2.LSB_done", {31'd0, LSB_done}, 32'd1);
    chk("st.c2.mem_wr", {31'd0, mem_wr}, 32'd0);
    tick(); LSB_req = 1'b0;
    tick();

    // Byte load of 0x21: zero-extended over the previous 0x513.
    LSB_req = 1'b1; LSB_wr = 1'b0; LSB_addr = 32'h21; LSB_size = 3'd1;
    repeat (3) tick();
    chk("ldb.LSB_done", {31'd0, LSB_done}, 32'd1);
    chk("ldb.LSB_rdata", LSB_rdata, 32'h0000_00CC);
    tick(); LSB_req = 1'b0;
    tick();

    // IO store stalled by a full UART buffer for three cycles.
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h0003_0000; LSB_size = 3'd1;
    LSB_wdata = 32'h0000_005A; io_buffer_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("io.hold.mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("io.wr.mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("io.wr.mem_a", mem_a, 32'h0003_0000);
    chk("io.wr.mem_dout", {24'd0, mem_dout}, 32'h5A);
    tick();
    chk("io.LSB_done", {31'd0, LSB_done}, 32'd1);
    tick(); LSB_req = 1'b0;
    tick();

    // clr in cycle 2 of a fetch: aborted, IF_data keeps 0x513.
    IF_req = 1'b1; IF_addr = 32'h20;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("clrif.mem_a", mem_a, 32'h20 + 32'(c));
    end
    clr = 1'b1;
    tick();
    clr = 1'b0; IF_req = 1'b0;
    chk("clrif.mem_a_abort", mem_a, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("clrif.no_done", {31'd0, IF_done}, 32'd0);
    end
    chk("clrif.IF_data", IF_data, 32'h0000_0513);

    // clr in cycle 1 of a word store: all four bytes still written.
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h40; LSB_size = 3'd4; LSB_wdata = 32'h1122_3344;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 2) clr = 1'b0;
      chk("clrst.mem_wr", {31'd0, mem_wr}, 32'd1);
      chk("clrst.mem_a", mem_a, 32'h40 + 32'(c));
      chk("clrst.mem_dout", {24'd0, mem_dout}, 32'(8'(32'h1122_3344 >> (8 * c))));
      if (c == 1) clr = 1'b1;
    end
    tick();
    chk("clrst.LSB_done", {31'd0, LSB_done}, 32'd1);
    tick(); LSB_req = 1'b0;
    tick();

    // clr in IDLE blocks the grant at that edge only.
    IF_req = 1'b1; IF_addr = 32'h1000; clr = 1'b1;
    tick();
    chk("clridle.no_grant", mem_a, 32'd0);
    clr = 1'b0;
    tick();
    chk("clridle.grant", mem_a, 32'h1000);
    wait_done(1'b1, 10);
    chk("clridle.IF_data", IF_data, 32'h0000_0513);
    tick(); IF_req = 1'b0;
    tick();

    // rdy low freezes a store mid-transfer.
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h50; LSB_size = 3'd2; LSB_wdata = 32'h0000_BEEF;
    tick();
    chk("rdy.c0.mem_dout", {24'd0, mem_dout}, 32'hEF);
    rdy = 1'b0;
    repeat (2) tick();
    chk("rdy.frozen.mem_a", mem_a, 32'h50);
    chk("rdy.frozen.mem_wr", {31'd0, mem_wr}, 32'd1);
    rdy = 1'b1;
    tick();
    chk("rdy.c1.mem_a", mem_a, 32'h51);
    chk("rdy.c1.mem_dout", {24'd0, mem_dout}, 32'hBE);
    tick();
    chk("rdy.LSB_done", {31'd0, LSB_done}, 32'd1);
    tick(); LSB_req = 1'b0;
    tick();

    // rst in cycle 1 of a load: abandoned with no done.
    LSB_req = 1'b1; LSB_wr = 1'b0; LSB_addr = 32'h1000; LSB_size = 3'd4;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rstld.mem_a", mem_a, 32'd0);
    chk("rstld.mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rstld.LSB_done", {31'd0, LSB_done}, 32'd0);
    chk("rstld.LSB_rdata", LSB_rdata, 32'd0);
    rst = 1'b0; LSB_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rstld.no_done", {31'd0, LSB_done}, 32'd0);
    end
    IF_req = 1'b1; IF_addr = 32'h20;
    tick();
    chk("rstld.idle_grant", mem_a, 32'h20);
    wait_done(1'b1, 10);
    chk("rstld.IF_data", IF_data, 32'h0000_CCDD);
    tick(); IF_req = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  system clock.
REQ-002 rst  input  1  reset; synchronous, active-high, sampled on the rising edge of clk.
REQ-003 rdy  input  1  global enable; when low, all state and outputs hold.
REQ-004 clr  input  1  misprediction rollback flush.
REQ-005 IF_req  input  1  instruction fetch request; held high until IF_done.
REQ-006 IF_addr  input  32  fetch byte address.
REQ-007 IF_done  output  1  one-cycle pulse; IF_data valid.
REQ-008 IF_data  output  32  fetched word, little-endian.
REQ-009 LSB_req  input  1  load/store request; held high until LSB_done.
REQ-010 LSB_wr  input  1  1 = store, 0 = load.
REQ-011 LSB_addr  input  32  byte address.
REQ-012 LSB_size  input  3  byte count: 1, 2 or 4.
REQ-013 LSB_wdata  input  32  store data; low LSB_size bytes used.
REQ-014 LSB_done  output  1  one-cycle pulse.
REQ-015 LSB_rdata  output  32  load data, zero-extended; the sign extension is done by the LSB.
REQ-016 mem_din  input  8  RAM read byte; valid one cycle after its address.
REQ-017 mem_dout  output  8  RAM write byte.
REQ-018 mem_a  output  32  RAM byte address.
REQ-019 mem_wr  output  1  1 = write.
REQ-020 io_buffer_full  input  1  UART buffer full.

Function
REQ-021 States SHALL be IDLE, IF_RD, LS_RD and LS_WR, with one byte counter of 3 bits.
REQ-022 Cycle k is the period after rising edge k; a request accepted at edge 0 drives mem_a = addr+k in cycle k, for k = 0..n-1.
REQ-023 A read SHALL sample byte k at edge k+1, assemble it at bits [8k+7:8k], and raise done with the data in cycle n+1.
REQ-024 A write SHALL drive mem_wr=1 and mem_dout=wdata[8k+7:8k] in cycle k, and raise done in cycle n.
REQ-025 An IF request is always 4 bytes.
REQ-026 Outside an active byte cycle, mem_wr=0, mem_a=0 and mem_dout=0.
REQ-027 Arbitration in IDLE SHALL follow these rules:
- Only one requester pending: it is granted.
- Both pending: grant the one not granted last; LSB wins the first tie after reset.
REQ-028 A requester whose done is high in a cycle SHALL NOT be sampled at the edge ending that cycle (no double grant); the other requester may be granted at that edge.
REQ-029 Before a write byte whose address has [17:16]=2'b11, if io_buffer_full=1, the byte cycle SHALL be held:
- mem_wr=0 and the counter does not advance.
- The byte is retried each cycle until io_buffer_full=0.
REQ-030 clr=1 SHALL affect each state as follows:
- IF_RD and LS_RD abort to IDLE at the next edge, with no done and no partial data exposed.
- LS_WR (store already committed) runs to completion.
- In IDLE, no grant is made at that edge.
REQ-031 When rdy=0, state, counter and all outputs SHALL freeze; the RAM timing contract is the caller's responsibility.
REQ-032 IF_data and LSB_rdata SHALL hold their last value between done pulses.

Reset
REQ-033 On rst, SHALL set: state=IDLE, counter=0, IF_done=LSB_done=0, IF_data=LSB_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, last-grant=IF.
REQ-034 rst in mid-transfer SHALL abandon the transfer at once and produce no done.

Structure
REQ-035 The state encoding, the size codes (1/2/4) and the IO address-range constant (2'b11 at [17:16]) SHALL live in the shared defines package.
REQ-036 The block SHALL have no sub-module: it is one FSM with a byte shifter.

Verification
REQ-037 IF_req, IF_addr=0x1000, RAM holding 0x13,0x05,0x00,0x00 -> mem_a 0x1000..0x1003 in cycles 0-3; IF_done in cycle 5 with IF_data=0x00000513.
REQ-038 LSB store, size 2, addr 0x20, wdata 0xAABBCCDD -> mem_wr=1 in cycles 0-1 with bytes 0xDD,0xCC at 0x20,0x21; LSB_done in cycle 2.
REQ-039 IF_req and LSB_req (load, size 4) raised together after reset -> LSB served first, IF granted at the LSB_done edge, and no second LSB grant.
REQ-040 Store byte to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one write of the byte; done the following cycle.
REQ-041 clr in cycle 2 of an IF read, and separately in cycle 1 of a size-4 store -> the read aborts with no IF_done; the store completes all 4 bytes and pulses LSB_done.
REQ-042 rst asserted in cycle 1 of a load -> cycle after reset: mem_a=0, mem_wr=0, no LSB_done, state IDLE.
